// File: rtl/kyber_pkg.sv
// Shared polynomial constants, encoder state type and the pass-to-lane map.
// Build option: POLY_ENC_REDUCE_EN selects canonical (mod q) byte encoding.
package kyber_pkg;

   localparam int KYBER_Q    = 3329;
   localparam int KYBER_N    = 256;
   localparam int COEFF_W    = 12;
   localparam int POLY_WORDS = 32;
   localparam int LANES      = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_CAP,
      S_SEND,
      S_DONE
   } enc_state_t;

   // Lower lane of the pair carrying coefficients 64*pass + 2*word (+1).
   function automatic logic [2:0] pass_lane(input logic [1:0] pass);
      logic [2:0] lane;
      unique case (pass)
         2'd0: lane = 3'd0;
         2'd1: lane = 3'd4;
         2'd2: lane = 3'd2;
         default: lane = 3'd6;
      endcase
      return lane;
   endfunction

endpackage

// File: rtl/poly_byte_encoder_packer.sv
// Packs two 12-bit coefficients into three ByteEncode_12 bytes.
// With POLY_ENC_REDUCE_EN, values >= q are reduced once before packing.
module coeff_pair_packer
   import kyber_pkg::*;
(
   input  logic [COEFF_W-1:0] c0,
   input  logic [COEFF_W-1:0] c1,
   output logic [23:0]        bits
);

   logic [COEFF_W-1:0] r0;
   logic [COEFF_W-1:0] r1;

`ifdef POLY_ENC_REDUCE_EN
   localparam logic [COEFF_W-1:0] Q = COEFF_W'(KYBER_Q);
   assign r0 = (c0 >= Q) ? c0 - Q : c0;
   assign r1 = (c1 >= Q) ? c1 - Q : c1;
`else
   assign r0 = c0;
   assign r1 = c1;
`endif

   // byte0 = r0[7:0], byte1 = {r1[3:0], r0[11:8]}, byte2 = r1[11:4]
   assign bits = {r1, r0};

endmodule

// File: rtl/poly_byte_encoder.sv
// Streams a sampler-layout polynomial from RAM as 384 ByteEncode_12 bytes.
// Build option: POLY_ENC_REDUCE_EN enables canonical reduction in the packer.
module poly_byte_encoder
   import kyber_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        active,
   input  logic [7:0]  ram_r_start_offset,
   output logic        ren,
   output logic [7:0]  raddr,
   input  logic [95:0] din,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [7:0]  dout,
   output logic        busy,
   output logic        done
);

   enc_state_t state;
   enc_state_t nstate;

   logic [7:0]  offset;
   logic [1:0]  pass;
   logic [4:0]  word;
   logic [1:0]  byte_cnt;
   logic [23:0] hold;

   logic [2:0]         lane;
   logic [COEFF_W-1:0] c0;
   logic [COEFF_W-1:0] c1;
   logic [23:0]        pair_bits;
   logic               last_byte;

   assign lane = pass_lane(pass);
   assign c0 = din[COEFF_W*int'(lane) +: COEFF_W];
   assign c1 = din[COEFF_W*(int'(lane)+1) +: COEFF_W];
   assign last_byte = dout_ready && (byte_cnt == 2'd2);

   coeff_pair_packer u_packer (
      .c0   (c0),
      .c1   (c1),
      .bits (pair_bits)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         offset   <= '0;
         pass     <= '0;
         word     <= '0;
         byte_cnt <= '0;
         hold     <= '0;
      end else begin
         state <= nstate;
         unique case (state)
            S_IDLE: begin
               if (active) begin
                  offset   <= ram_r_start_offset;
                  pass     <= '0;
                  word     <= '0;
                  byte_cnt <= '0;
               end
            end
            S_CAP: hold <= pair_bits;
            S_SEND: begin
               if (last_byte) begin
                  byte_cnt <= '0;
                  word     <= word + 5'd1;
                  if (word == 5'd31) pass <= pass + 2'd1;
               end else if (dout_ready) begin
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE: if (active) nstate = S_REQ;
         S_REQ:  nstate = S_CAP;
         S_CAP:  nstate = S_SEND;
         S_SEND: begin
            if (last_byte)
               nstate = (pass == 2'd3 && word == 5'd31) ? S_DONE : S_REQ;
         end
         default: nstate = S_IDLE;
      endcase
   end

   always_comb begin
      ren        = (state == S_REQ);
      raddr      = ren ? offset + {3'b000, word} : 8'h00;
      dout_valid = (state == S_SEND);
      busy       = (state == S_REQ) || (state == S_CAP) || (state == S_SEND);
      done       = (state == S_DONE);
      dout       = 8'h00;
      if (dout_valid) begin
         unique case (byte_cnt)
            2'd0:    dout = hold[7:0];
            2'd1:    dout = hold[15:8];
            default: dout = hold[23:16];
         endcase
      end
   end

endmodule

// File: tb/tb_poly_byte_encoder.sv
// Directed bench for poly_byte_encoder with a byte/address scoreboard.
// Honours POLY_ENC_REDUCE_EN in its reference model.
module tb_poly_byte_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        active;
   logic [7:0]  ram_r_start_offset;
   logic        ren;
   logic [7:0]  raddr;
   logic [95:0] din = '0;
   logic        dout_valid;
   logic        dout_ready;
   logic [7:0]  dout;
   logic        busy;
   logic        done;

   logic [95:0] mem [256];
   logic [11:0] coef [256];
   logic [7:0]  got [384];
   logic [7:0]  exp_q [$];
   logic [7:0]  addr_q [$];
   int          lane_src [8] = '{0, 1, 128, 129, 64, 65, 192, 193};

   int checks = 0;
   int passed = 0;
   int nb;

   poly_byte_encoder dut (
      .clk                (clk),
      .rst                (rst),
      .active             (active),
      .ram_r_start_offset (ram_r_start_offset),
      .ren                (ren),
      .raddr              (raddr),
      .din                (din),
      .dout_valid         (dout_valid),
      .dout_ready         (dout_ready),
      .dout               (dout),
      .busy               (busy),
      .done               (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ren) din <= mem[raddr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [11:0] red(input logic [11:0] c);
`ifdef POLY_ENC_REDUCE_EN
      return (c >= 12'd3329) ? c - 12'd3329 : c;
`else
      return c;
`endif
   endfunction

   task automatic scramble_mem();
      for (int a = 0; a < 256; a++)
         mem[a] = {$urandom, $urandom, $urandom};
   endtask

   task automatic load(input logic [7:0] off);
      logic [95:0] w;
      for (int k = 0; k < 32; k++) begin
         w = '0;
         for (int j = 0; j < 8; j++)
            w[12*j +: 12] = coef[2*k + lane_src[j]];
         mem[8'(off + 8'(k))] = w;
      end
   endtask

   task automatic run(input logic [7:0] off, input int stall, input int abort_at,
                      input bit poke, input bit timed, output int n);
      logic [11:0] a;
      logic [11:0] b;
      logic [7:0]  prev;
      bit          stalled;
      bit          poked;
      int          dones;
      int          cyc;
      exp_q.delete();
      addr_q.delete();
      for (int i = 0; i < 128; i++) begin
         a = red(coef[2*i]);
         b = red(coef[2*i+1]);
         exp_q.push_back(a[7:0]);
         exp_q.push_back({b[3:0], a[11:8]});
         exp_q.push_back(b[11:4]);
      end
      for (int p = 0; p < 4; p++)
         for (int w = 0; w < 32; w++)
            addr_q.push_back(8'(off + 8'(w)));
      n = 0; dones = 0; stalled = 0; poked = 0; prev = 0; cyc = 0;
      ram_r_start_offset = off;
      dout_ready = 1'b1;
      active = 1'b1;
      @(negedge clk);
      active = 1'b0;
      while (cyc < 5000) begin
         dout_ready = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
         if (cyc == 0) begin
            chk("start_ren", ren, 1);
            chk("start_busy", busy, 1);
         end
         if (timed && cyc == 2) chk("first_valid", dout_valid, 1);
         if (stalled) begin
            chk("stall_valid", dout_valid, 1);
            chk("stall_dout", dout, prev);
         end
         if (ren) begin
            if (addr_q.size() == 0) chk("raddr_extra", 1, 0);
            else chk("raddr", raddr, addr_q.pop_front());
         end else begin
            chk("raddr_idle", raddr, 0);
         end
         stalled = dout_valid && !dout_ready;
         prev = dout;
         if (dout_valid && dout_ready) begin
            if (n < 384) got[n] = dout;
            if (exp_q.size() == 0) chk("byte_extra", 1, 0);
            else chk("byte", dout, exp_q.pop_front());
            n++;
         end
         if (done) begin
            dones++;
            if (timed) chk("done_cycle", cyc, 640);
            break;
         end
         if (poke && !poked && n == 50) begin
            active = 1'b1;
            poked = 1'b1;
         end else begin
            active = 1'b0;
         end
         if (abort_at >= 0 && n == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            chk("abort_ren", ren, 0);
            chk("abort_raddr", raddr, 0);
            chk("abort_valid", dout_valid, 0);
            chk("abort_dout", dout, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            rst = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (done) dones++;
            end
            chk("abort_no_done", dones, 0);
            chk("abort_idle", busy, 0);
            exp_q.delete();
            addr_q.delete();
            return;
         end
         @(negedge clk);
         cyc++;
      end
      active = 1'b0;
      chk("byte_count", n, 384);
      chk("done_count", dones, 1);
      chk("bytes_left", exp_q.size(), 0);
      chk("reads_left", addr_q.size(), 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      active = 1'b0;
      dout_ready = 1'b0;
      ram_r_start_offset = 8'h00;
      scramble_mem();
      repeat (3) @(negedge clk);
      chk("rst_ren", ren, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);

      // natural ramp, offset 0
      for (int j = 0; j < 256; j++) coef[j] = 12'(j);
      load(8'h00);
      run(8'h00, 0, -1, 0, 1, nb);
      chk("ramp_b0", got[0], 8'h00);
      chk("ramp_b1", got[1], 8'h10);
      chk("ramp_b2", got[2], 8'h00);
      chk("ramp_b3", got[3], 8'h02);
      chk("ramp_b4", got[4], 8'h30);
      chk("ramp_b5", got[5], 8'h00);
      chk("ramp_b96", got[96], 8'h40);
      chk("ramp_b97", got[97], 8'h10);
      chk("ramp_b98", got[98], 8'h04);
      chk("ramp_b381", got[381], 8'hFE);
      chk("ramp_b382", got[382], 8'hF0);
      chk("ramp_b383", got[383], 8'h0F);

      // all lanes 0xFFF
      for (int j = 0; j < 256; j++) coef[j] = 12'hFFF;
      load(8'h00);
      run(8'h00, 0, -1, 0, 1, nb);
`ifdef POLY_ENC_REDUCE_EN
      chk("fff_b0", got[0], 8'hFE);
      chk("fff_b1", got[1], 8'hE2);
      chk("fff_b2", got[2], 8'h2F);
      chk("fff_b383", got[383], 8'h2F);
`else
      chk("fff_b0", got[0], 8'hFF);
      chk("fff_b1", got[1], 8'hFF);
      chk("fff_b2", got[2], 8'hFF);
      chk("fff_b383", got[383], 8'hFF);
`endif

      // random coefficients under ~50% backpressure
      scramble_mem();
      for (int j = 0; j < 256; j++) coef[j] = 12'($urandom);
      load(8'h00);
      run(8'h00, 50, -1, 0, 0, nb);

      // wrapping base address
      scramble_mem();
      for (int j = 0; j < 256; j++) coef[j] = 12'(j);
      load(8'hF0);
      run(8'hF0, 0, -1, 0, 1, nb);
      chk("wrap_b3", got[3], 8'h02);

      // reset after the 100th byte, then a clean restart
      load(8'h00);
      run(8'h00, 0, 100, 0, 0, nb);
      run(8'h00, 0, -1, 0, 1, nb);
      chk("restart_b98", got[98], 8'h04);

      // start pulse while busy is ignored
      run(8'h00, 30, -1, 1, 0, nb);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
